reset_seq: RTL and testbench



---
 rtl/reset_seq.sv | 138 +++++++++++++
 tb/tb_reset_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// reset_seq: multi-channel reset sequencer.
// Syncs the async reset, stretches, then releases channels in index order.
module reset_seq #(
  parameter int N_CH           = 4,
  parameter int N_SYNC         = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int CTR_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n_in_fp,
  input  logic [N_CH-1:0] sw_rst_req,
  output logic [N_CH-1:0] rst_n_out,
  output logic            all_released,
  output logic            seq_busy
);

  localparam int LP_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CTR_W-1:0] STR_LD = CTR_W'(STRETCH_CYCLES - 1);
  localparam logic [CTR_W-1:0] GAP_LD = CTR_W'(GAP_CYCLES - 1);
  localparam logic [LP_W-1:0]  LP_LAST = LP_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [N_SYNC-1:0] r_sync;
  logic [LP_W-1:0]   r_lp;
  logic [LP_W-1:0]   w_lp_nx;
  logic [LP_W-1:0]   w_j;
  logic [CTR_W-1:0]  r_ctr;
  logic [CTR_W-1:0]  w_ctr_nx;
  logic [N_CH-1:0]   r_out;
  logic [N_CH-1:0]   w_out_nx;
  logic [N_CH-1:0]   w_clr;
  logic              r_all;
  logic              r_busy;
  logic              r_req_d;
  logic              w_sync;
  logic              w_req;
  logic              w_rel;

  assign w_sync = r_sync[N_SYNC-1];
  assign w_req  = w_sync & (|sw_rst_req);

  assign rst_n_out    = r_out;
  assign all_released = r_all;
  assign seq_busy     = r_busy;

  // Lowest requested channel; everything at or above it is re-asserted.
  always_comb begin
    w_j = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (sw_rst_req[i]) w_j = LP_W'(i);
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_CH; i++)
      w_clr[i] = (LP_W'(i) >= w_j);
  end

  always_ff @(posedge clk or negedge rst_n_in_fp) begin
    if (!rst_n_in_fp) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_SYNC-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n_in_fp) begin
    if (!rst_n_in_fp) begin
      r_state <= S_HOLD;
      r_lp    <= '0;
      r_ctr   <= '0;
      r_out   <= '0;
      r_all   <= 1'b0;
      r_busy  <= 1'b1;
      r_req_d <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lp    <= w_lp_nx;
      r_ctr   <= w_ctr_nx;
      r_out   <= w_out_nx;
      r_all   <= &w_out_nx;
      r_busy  <= (w_state_nx != S_RUN);
      r_req_d <= w_req;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_lp_nx    = r_lp;
    w_ctr_nx   = r_ctr;
    w_out_nx   = r_out;
    w_rel      = 1'b0;
    if (w_req) begin
      w_state_nx = S_HOLD;
      w_ctr_nx   = '0;
      w_out_nx   = r_out & ~w_clr;
      if (r_state == S_RUN || w_j < r_lp)
        w_lp_nx = w_j;
    end else begin
      unique case (r_state)
        S_HOLD: begin
          // r_req_d gives one quiet edge after a request drops
          if (w_sync && !r_req_d) begin
            w_state_nx = S_STRETCH;
            w_ctr_nx   = STR_LD;
          end
        end
        S_STRETCH,
        S_RELEASE: begin
          if (r_ctr == '0) w_rel = 1'b1;
          else w_ctr_nx = r_ctr - 1'b1;
        end
        S_RUN: ;
      endcase
      if (w_rel) begin
        for (int i = 0; i < N_CH; i++)
          if (LP_W'(i) == r_lp) w_out_nx[i] = 1'b1;
        if (r_lp == LP_LAST) begin
          w_state_nx = S_RUN;
        end else begin
          w_lp_nx    = r_lp + 1'b1;
          w_state_nx = S_RELEASE;
          w_ctr_nx   = GAP_LD;
        end
      end
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: scoreboard bench for reset_seq.
// Release schedule model feeds a per-edge expectation queue.
module tb_reset_seq;

  localparam int NC = 4;
  localparam int NS = 3;
  localparam int ST = 16;
  localparam int GP = 8;

  logic          clk = 1'b0;
  logic          rst_n_in_fp = 1'b0;
  logic [NC-1:0] sw_rst_req = '0;
  logic [NC-1:0] rst_n_out;
  logic          all_released;
  logic          seq_busy;

  logic rst_b = 1'b0;
  logic sw_b = 1'b0;
  logic out_b;
  logic all_b;
  logic busy_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  reset_seq #(
    .N_CH(NC), .N_SYNC(NS), .STRETCH_CYCLES(ST),
    .GAP_CYCLES(GP), .CTR_W(8)
  ) u_dut (
    .clk          (clk),
    .rst_n_in_fp  (rst_n_in_fp),
    .sw_rst_req   (sw_rst_req),
    .rst_n_out    (rst_n_out),
    .all_released (all_released),
    .seq_busy     (seq_busy)
  );

  reset_seq #(
    .N_CH(1), .N_SYNC(2), .STRETCH_CYCLES(1),
    .GAP_CYCLES(1), .CTR_W(8)
  ) u_min (
    .clk          (clk),
    .rst_n_in_fp  (rst_b),
    .sw_rst_req   (sw_b),
    .rst_n_out    (out_b),
    .all_released (all_b),
    .seq_busy     (busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NC-1:0] o;
    logic          a;
    logic          b;
  } exp_t;

  exp_t q[$];

  // Reference: absolute release edge per channel, rebuilt on every restart.
  logic [NC-1:0] m_out = '0;
  int            m_rel[NC];
  int            m_since = 0;
  bit            m_wait = 0;

  always @(posedge clk) begin
    int j;
    int lp;
    exp_t e;
    cyc++;
    if (!rst_n_in_fp) begin
      m_out   = '0;
      m_since = 0;
      m_wait  = 0;
      for (int i = 0; i < NC; i++) m_rel[i] = -1;
    end else begin
      m_since++;
      if (m_since == 1)
        for (int i = 0; i < NC; i++) m_rel[i] = cyc + NS + ST + i * GP;
      if (m_since >= NS + 1 && sw_rst_req != '0) begin
        j = NC;
        for (int i = NC - 1; i >= 0; i--) if (sw_rst_req[i]) j = i;
        for (int i = 0; i < NC; i++) begin
          if (i >= j) m_out[i] = 1'b0;
          m_rel[i] = -1;
        end
        m_wait = 1;
      end else begin
        if (m_wait) begin
          lp = NC;
          for (int i = NC - 1; i >= 0; i--) if (!m_out[i]) lp = i;
          for (int i = 0; i < NC; i++)
            if (i >= lp) m_rel[i] = cyc + ST + 1 + (i - lp) * GP;
          m_wait = 0;
        end
        for (int i = 0; i < NC; i++)
          if (m_rel[i] == cyc) m_out[i] = 1'b1;
      end
    end
    e.o = m_out;
    e.a = &m_out;
    e.b = ~&m_out;
    q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("rst_n_out", 32'(rst_n_out), 32'(e.o));
      chk("all_released", 32'(all_released), 32'(e.a));
      chk("seq_busy", 32'(seq_busy), 32'(e.b));
    end
  end

  task automatic pulse(input logic [NC-1:0] v, input int n);
    @(negedge clk);
    sw_rst_req = v;
    repeat (n) @(negedge clk);
    sw_rst_req = '0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #3;
    rst_n_in_fp = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #3;
    rst_n_in_fp = 1'b1;
    repeat (60) @(negedge clk);

    pulse(4'b0100, 1);
    repeat (40) @(negedge clk);

    pulse(4'b0001, 1);
    n = 0;
    while (n < 100 && rst_n_out[1] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ch1_release", 32'(rst_n_out[1]), 32'd1);
    repeat (3) @(negedge clk);
    pulse(4'b0001, 1);
    repeat (70) @(negedge clk);

    pulse(4'b0010, 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n_in_fp = 1'b0;
    #1;
    chk("async_out", 32'(rst_n_out), 32'd0);
    chk("async_all", 32'(all_released), 32'd0);
    chk("async_busy", 32'(seq_busy), 32'd1);
    repeat (2) @(posedge clk);
    release_rst();
    repeat (60) @(negedge clk);

    pulse(4'b1010, 50);
    repeat (60) @(negedge clk);

    repeat (14) begin
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk);
        #3;
        rst_n_in_fp = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n_in_fp = 1'b1;
      end else begin
        pulse(NC'($urandom_range(1, 15)), $urandom_range(1, 4));
      end
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    repeat (70) @(negedge clk);
    chk("final_all_released", 32'(all_released), 32'd1);

    @(posedge clk);
    #3;
    rst_b = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      chk("min_out", 32'(out_b), 32'(e >= 4));
      chk("min_all", 32'(all_b), 32'(e >= 4));
      chk("min_busy", 32'(busy_b), 32'(e < 4));
    end
    @(negedge clk);
    sw_b = 1'b1;
    @(posedge clk);
    #1;
    chk("min_req_out", 32'(out_b), 32'd0);
    chk("min_req_busy", 32'(busy_b), 32'd1);
    @(negedge clk);
    sw_b = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk("min_rerel_out", 32'(out_b), 32'(e >= 3));
      chk("min_rerel_all", 32'(all_b), 32'(e >= 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
